// File: rtl/aes_byte_sequencer.sv
// Byte-serial front end for a 128-bit AES core: gathers 16 plaintext and 16 key
// bytes, launches the core, and streams the 16 ciphertext bytes back out.
module aes_byte_sequencer #(
    parameter int TIMEOUT = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [7:0]   out_data,
    input  logic         out_ready,
    output logic         core_load,
    output logic [127:0] core_plaintext,
    output logic [127:0] core_key,
    input  logic         core_done,
    input  logic [127:0] core_cyphertext,
    output logic         busy,
    output logic         err_timeout
);
    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE_IN, START, WAIT, DRAIN} state_t;

    state_t         state;
    logic [4:0]     cnt;
    logic [WW-1:0]  wait_cnt;
    // Bytes 1..15 still to be drained; byte 0 goes straight into out_data.
    logic [119:0]   ct;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE_IN;
            cnt            <= '0;
            wait_cnt       <= '0;
            ct             <= '0;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            out_data       <= '0;
            core_load      <= 1'b0;
            core_plaintext <= '0;
            core_key       <= '0;
            busy           <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            core_load   <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE_IN: begin
                    if (in_valid) begin
                        if (!cnt[4]) core_plaintext <= {core_plaintext[119:0], in_data};
                        else         core_key       <= {core_key[119:0], in_data};
                        if (cnt == 5'd31) begin
                            cnt       <= '0;
                            state     <= START;
                            core_load <= 1'b1;
                            in_ready  <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        ct        <= core_cyphertext[119:0];
                        out_data  <= core_cyphertext[127:120];
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        wait_cnt  <= '0;
                        state     <= DRAIN;
                    end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                        // TIMEOUT WAIT cycles have elapsed with no result.
                        err_timeout <= 1'b1;
                        wait_cnt    <= '0;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE_IN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (cnt == 5'd15) begin
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE_IN;
                        end else begin
                            cnt      <= cnt + 5'd1;
                            out_data <= ct[119:112];
                            ct       <= {ct[111:0], 8'h00};
                        end
                    end
                end
                default: begin
                    state    <= IDLE_IN;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_byte_sequencer.sv
// Bench for aes_byte_sequencer: a stub AES core answers known vectors and a
// keyed mixing function otherwise; outputs are checked against byte-level models.
module tb_aes_byte_sequencer;
    localparam logic [127:0] A1_PT  = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] A1_KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] A1_CT  = 128'h3925841D02DC09FBDC118597196A0B32;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] C1_CT  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    localparam logic [127:0] BOGUS  = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;

    typedef logic [7:0] blk_t [32];

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         out_ready = 1'b1;
    logic         core_load;
    logic [127:0] core_plaintext, core_key;
    logic         core_done = 1'b0;
    logic [127:0] core_cyphertext = '0;
    logic         busy, err_timeout;

    aes_byte_sequencer #(.TIMEOUT(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .core_load(core_load), .core_plaintext(core_plaintext), .core_key(core_key),
        .core_done(core_done), .core_cyphertext(core_cyphertext),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;
    int cyc = 0;
    initial forever begin @(posedge clk); cyc++; end

    // Stand-in for the AES core: known vectors, otherwise a keyed mix.
    function automatic logic [127:0] core_fn(input logic [127:0] p, input logic [127:0] k);
        if (p == A1_PT && k == A1_KEY) return A1_CT;
        if (p == C1_PT && k == C1_KEY) return C1_CT;
        return p ^ {k[63:0], k[127:64]} ^ 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    endfunction

    int           stub_lat = 4;
    bit           armed = 0;
    int           wcnt = 0;
    logic [127:0] cap_pt, cap_key;
    initial forever begin
        @(negedge clk);
        if (core_load) begin
            armed = 1; wcnt = 0; cap_pt = core_plaintext; cap_key = core_key;
        end else if (armed) begin
            wcnt++;
            if (stub_lat > 0 && wcnt >= stub_lat) begin
                core_done = 1'b1; core_cyphertext = core_fn(cap_pt, cap_key);
            end else begin
                core_done = 1'b0;
            end
        end
    end

    bit rdy_rand = 0;
    initial forever begin
        @(posedge clk); #1;
        out_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    logic [7:0] outq[$];
    int         out_cyc[$], in_cyc[$];
    int         stall_err = 0, zero_err = 0, ov_cycles = 0, ld_cnt = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = '0;
    initial forever begin
        @(negedge clk);
        if (reset) prev_stall = 0;
        else begin
            if (out_valid) ov_cycles++;
            if (core_load) ld_cnt++;
            if (!out_valid && out_data !== 8'h00) zero_err++;
            if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin outq.push_back(out_data); out_cyc.push_back(cyc + 1); end
            if (in_valid && in_ready) in_cyc.push_back(cyc + 1);
        end
    end

    task automatic clear_mon();
        outq.delete(); out_cyc.delete(); in_cyc.delete(); ld_cnt = 0;
    endtask

    task automatic mk_blk(input logic [127:0] p, input logic [127:0] k, output blk_t b);
        for (int i = 0; i < 16; i++) begin
            b[i]      = p[127-8*i -: 8];
            b[i + 16] = k[127-8*i -: 8];
        end
    endtask

    task automatic rand_blk(output blk_t b, output logic [127:0] p, output logic [127:0] k);
        for (int i = 0; i < 32; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) begin
            p[127-8*i -: 8] = b[i];
            k[127-8*i -: 8] = b[i + 16];
        end
    endtask

    function automatic logic [127:0] pack16(input logic [7:0] q[$], input int base);
        logic [127:0] v = '0;
        for (int i = 0; i < 16; i++)
            if (base + i < q.size()) v[127-8*i -: 8] = q[base + i];
        return v;
    endfunction

    // Called in the posedge+1 phase; returns in the cycle after the last byte is taken.
    task automatic send_block(input blk_t b, input bit gaps, output bit ok);
        int n;
        ok = 1;
        for (int i = 0; i < 32; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            in_valid = 1'b1; in_data = b[i]; n = 0;
            @(negedge clk);
            while (!in_ready && n < 2000) begin @(negedge clk); n++; end
            if (!in_ready) ok = 0;
            @(posedge clk); #1;
            in_valid = 1'b0; in_data = 8'($urandom);
        end
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (outq.size() < n && k < 2000) begin @(posedge clk); #1; k++; end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({in_ready, out_valid, out_data, core_load, busy, err_timeout} !== 13'b1_0_00000000_0_0_0) begin
            mismatched++;
            $display("FAIL reset_ctl: got %b want %b", {in_ready, out_valid, out_data, core_load, busy, err_timeout}, 13'b1_0_00000000_0_0_0);
        end
        compared++;
        if ({core_plaintext, core_key} !== 256'h0) begin
            mismatched++; $display("FAIL reset_core: got %h %h want 0", core_plaintext, core_key);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_a1();
        blk_t b; bit ok;
        clear_mon(); rdy_rand = 0; stub_lat = 5;
        mk_blk(A1_PT, A1_KEY, b);
        send_block(b, 0, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL a1_accept: got stalled input want accepted"); end
        compared++;
        if ({core_load, busy, in_ready} !== 3'b110) begin
            mismatched++; $display("FAIL a1_load: got load/busy/ready=%b want 110", {core_load, busy, in_ready});
        end
        compared++;
        if (core_plaintext !== A1_PT || core_key !== A1_KEY) begin
            mismatched++; $display("FAIL a1_core_in: got %h %h want %h %h", core_plaintext, core_key, A1_PT, A1_KEY);
        end
        @(posedge clk); #1;
        compared++;
        if (core_load !== 1'b0) begin mismatched++; $display("FAIL a1_load_width: got %b want 0", core_load); end
        wait_out(16);
        compared++;
        if (outq.size() != 16 || pack16(outq, 0) !== A1_CT) begin
            mismatched++; $display("FAIL a1_out: got %0d bytes %h want 16 bytes %h", outq.size(), pack16(outq, 0), A1_CT);
        end
        compared++;
        if ({out_valid, in_ready, busy, ld_cnt == 1} !== 4'b0101) begin
            mismatched++; $display("FAIL a1_after: got valid/ready/busy/oneload=%b want 0101", {out_valid, in_ready, busy, ld_cnt == 1});
        end
        compared++;
        if (core_plaintext !== A1_PT || core_key !== A1_KEY) begin
            mismatched++; $display("FAIL a1_hold: got %h %h want %h %h", core_plaintext, core_key, A1_PT, A1_KEY);
        end
    endtask

    task automatic test_back_to_back();
        blk_t b1, b2; bit ok1, ok2;
        clear_mon(); rdy_rand = 0; stub_lat = 3;
        mk_blk(A1_PT, A1_KEY, b1);
        mk_blk(C1_PT, C1_KEY, b2);
        send_block(b1, 0, ok1);
        send_block(b2, 0, ok2);
        wait_out(32);
        compared++;
        if (!(ok1 && ok2) || pack16(outq, 0) !== A1_CT || pack16(outq, 16) !== C1_CT) begin
            mismatched++; $display("FAIL b2b_out: got %h %h want %h %h", pack16(outq, 0), pack16(outq, 16), A1_CT, C1_CT);
        end
        compared++;
        if (in_cyc.size() < 33 || out_cyc.size() < 16 || in_cyc[32] != out_cyc[15] + 1) begin
            mismatched++;
            $display("FAIL b2b_gap: got first C1 accept at %0d want %0d",
                     (in_cyc.size() > 32) ? in_cyc[32] : -1, (out_cyc.size() > 15) ? out_cyc[15] + 1 : -1);
        end
    endtask

    task automatic test_backpressure();
        blk_t b; bit ok; logic [127:0] p, k, exp_ct;
        for (int r = 0; r < 3; r++) begin
            clear_mon(); rdy_rand = 1; stub_lat = $urandom_range(1, 20);
            rand_blk(b, p, k);
            exp_ct = core_fn(p, k);
            send_block(b, 1, ok);
            wait_out(16);
            repeat (20) begin @(posedge clk); #1; end
            compared++;
            if (!ok || outq.size() != 16 || pack16(outq, 0) !== exp_ct) begin
                mismatched++; $display("FAIL bp_out%0d: got %0d bytes %h want 16 bytes %h", r, outq.size(), pack16(outq, 0), exp_ct);
            end
        end
        rdy_rand = 0;
        compared++;
        if (stall_err != 0 || zero_err != 0) begin
            mismatched++; $display("FAIL bp_stable: got stall_err=%0d zero_err=%0d want 0 0", stall_err, zero_err);
        end
    endtask

    // Pulse expected in the cycle after the 32nd WAIT cycle (START is cycle 0).
    task automatic test_timeout();
        blk_t b; bit ok; logic [127:0] p, k, exp_ct;
        int first = -1, pulses = 0, ov0; logic busy32 = 1'b0, ready_at = 1'b0;
        clear_mon(); rdy_rand = 0; stub_lat = 0;
        rand_blk(b, p, k);
        send_block(b, 0, ok);
        ov0 = ov_cycles;
        compared++;
        if (!ok || core_load !== 1'b1) begin mismatched++; $display("FAIL to_load: got %b want 1", core_load); end
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 32) busy32 = busy;
            if (err_timeout) begin
                pulses++;
                if (first < 0) begin first = n; ready_at = in_ready && !busy; end
            end
        end
        compared++;
        if (first != 33 || pulses != 1) begin
            mismatched++; $display("FAIL to_pulse: got cycle %0d width %0d want cycle 33 width 1", first, pulses);
        end
        compared++;
        if ({busy32, ready_at} !== 2'b11 || ov_cycles != ov0) begin
            mismatched++; $display("FAIL to_state: got busy32/idle=%b out_valid_cycles=%0d want 11 0", {busy32, ready_at}, ov_cycles - ov0);
        end
        clear_mon(); stub_lat = 4;
        rand_blk(b, p, k);
        exp_ct = core_fn(p, k);
        send_block(b, 0, ok);
        wait_out(16);
        compared++;
        if (!ok || pack16(outq, 0) !== exp_ct) begin
            mismatched++; $display("FAIL to_recover: got %h want %h", pack16(outq, 0), exp_ct);
        end
    endtask

    task automatic test_stale_done();
        blk_t b; bit ok;
        clear_mon(); rdy_rand = 0;
        armed = 0; core_done = 1'b1; core_cyphertext = BOGUS; stub_lat = 3;
        mk_blk(C1_PT, C1_KEY, b);
        send_block(b, 0, ok);
        wait_out(16);
        compared++;
        if (!ok || pack16(outq, 0) !== C1_CT) begin
            mismatched++; $display("FAIL stale_out: got %h want %h", pack16(outq, 0), C1_CT);
        end
    endtask

    task automatic test_mid_reset();
        blk_t b; bit ok;
        logic [127:0] p, k;
        clear_mon(); rdy_rand = 0;
        rand_blk(b, p, k);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = b[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        compared++;
        if ({in_ready, busy, out_valid} !== 3'b100 || core_plaintext !== 128'h0) begin
            mismatched++; $display("FAIL mr_async: got ready/busy/valid=%b pt=%h want 100 0", {in_ready, busy, out_valid}, core_plaintext);
        end
        @(posedge clk); #1;
        reset = 1'b0; armed = 0; core_done = 1'b0;
        clear_mon(); stub_lat = 6;
        mk_blk(A1_PT, A1_KEY, b);
        send_block(b, 0, ok);
        wait_out(16);
        compared++;
        if (!ok || pack16(outq, 0) !== A1_CT) begin
            mismatched++; $display("FAIL mr_out: got %h want %h", pack16(outq, 0), A1_CT);
        end
    endtask

    initial begin
        test_reset();
        test_a1();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_stale_done();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/aes_byte_sequencer.md
AES_BYTE_SEQUENCER -- requirements
Module: aes_byte_sequencer

Interface
REQ-001 SHALL have port clk  input  1  rising-edge system clock.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port in_valid  input  1  upstream byte valid.
REQ-004 SHALL have port in_data  input  8  upstream byte.
REQ-005 SHALL have port in_ready  output  1  sequencer accepts byte.
REQ-006 SHALL have port out_valid  output  1  ciphertext byte valid.
REQ-007 SHALL have port out_data  output  8  ciphertext byte.
REQ-008 SHALL have port out_ready  input  1  downstream accepts byte.
REQ-009 SHALL have port core_load  output  1  load/reset pulse to AES core.
REQ-010 SHALL have port core_plaintext  output  128  plaintext to AES core.
REQ-011 SHALL have port core_key  output  128  key to AES core.
REQ-012 SHALL have port core_done  input  1  AES core done level.
REQ-013 SHALL have port core_cyphertext  input  128  AES core result.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE_IN.
REQ-015 SHALL have port err_timeout  output  1  one-cycle pulse on core timeout.
REQ-016 SHALL have parameter TIMEOUT, default 32, meaning the maximum number of WAIT cycles before abort.

Function
REQ-017 SHALL define a byte transfer as in_valid&&in_ready, or out_valid&&out_ready, at the rising edge of clk.
REQ-018 SHALL implement the states IDLE_IN, START, WAIT and DRAIN.
REQ-019 SHALL drive in_ready=1 only in IDLE_IN.
REQ-020 SHALL, in IDLE_IN, count accepted bytes 0..31 with a 5-bit counter.
- Bytes 0-15 load core_plaintext MSB-first: byte 0 -> [127:120], byte 15 -> [7:0].
- Bytes 16-31 load core_key MSB-first.
REQ-021 SHALL transition IDLE_IN->START on acceptance of byte 31 and SHALL reset the counter to 0.
REQ-022 SHALL assert core_load for exactly one cycle, in START, then go to WAIT.
REQ-023 SHALL hold core_plaintext and core_key stable from START through the end of DRAIN.
REQ-024 SHALL sample core_done only in WAIT; any core_done value in START or IDLE_IN SHALL be ignored.
REQ-025 SHALL, on the first WAIT cycle with core_done=1, capture core_cyphertext into a 128-bit output register and go to DRAIN.
REQ-026 SHALL count WAIT cycles and, if the count reaches TIMEOUT without core_done, do all of the following:
- pulse err_timeout for one cycle;
- return to IDLE_IN;
- emit no output bytes.
REQ-027 SHALL, in DRAIN, present captured bytes MSB-first (byte 0 = [127:120]) with out_valid=1.
REQ-028 SHALL hold out_data constant while out_valid&&!out_ready.
REQ-029 SHALL advance to the next byte only on an output transfer, and SHALL never duplicate or drop a byte.
REQ-030 SHALL return to IDLE_IN on the transfer of output byte 15, with out_valid low in the following cycle.
REQ-031 SHALL accept a new byte in the first IDLE_IN cycle after DRAIN, so that back-to-back blocks are supported.
REQ-032 SHALL drive out_data=0 whenever out_valid=0.

Reset
REQ-033 SHALL, on reset, asynchronously force the following, regardless of the current state:
- state=IDLE_IN, byte counter=0, WAIT counter=0;
- in_ready=1, out_valid=0, out_data=0;
- core_load=0, core_plaintext=0, core_key=0;
- busy=0, err_timeout=0.
REQ-034 SHALL discard any partially received or partially drained block on reset.

Verification
REQ-035 SHALL pass the FIPS-197 A.1 directed test with the real AES core: bytes 32 43 F6 A8 88 5A 30 8D 31 31 98 A2 E0 37 07 34 then 2B 7E 15 16 28 AE D2 A6 AB F7 15 88 09 CF 4F 3C -> core_load high exactly one cycle after byte 31, output 39 25 84 1D 02 DC 09 FB DC 11 85 97 19 6A 0B 32.
REQ-036 SHALL pass a back-to-back test: the C.1 vector (plaintext 00112233..EEFF, key 00010203..0E0F) sent immediately after the A.1 drain -> output 69 C4 E0 D8 6A 7B 04 30 D8 CD B7 80 70 B4 C5 5A.
REQ-037 SHALL pass a backpressure test: random out_ready and in_valid gaps -> identical byte sequence, out_data stable during stalls, exactly 16 output transfers.
REQ-038 SHALL pass a timeout test: core stubbed with core_done=0 -> err_timeout pulses on WAIT cycle 32, state returns to IDLE_IN, out_valid never asserted.
REQ-039 SHALL pass a mid-input reset test: reset asserted after 10 input bytes, then the full A.1 vector -> output 39 25 84 1D ... 0B 32.
REQ-040 SHALL pass a stale-done test: core stub holds core_done=1 during START -> done ignored, and capture occurs only on WAIT-state core_done.
